// File: rtl/zorro_pkg.sv
// zorro_pkg: shared states, targets, region selects and decode helper for the Zorro III cycle sequencer
package zorro_pkg;
  typedef enum logic [2:0] {IDLE, DECODE, WAIT_DS, ACTIVE, ACK, RECOVER} state_t;
  typedef enum logic [1:0] {T_NONE, T_ROM, T_SCSI, T_SID} target_t;
  localparam logic [3:0] ROM_SEL_DEF = 4'h0;
  localparam logic [3:0] SCSI_SEL_DEF = 4'h8;
  localparam logic [3:0] SID_SEL_DEF = 4'hC;
  function automatic target_t decode_target(input logic [3:0] a, r, s, i);
    return a == r ? T_ROM : a == s ? T_SCSI : a == i ? T_SID : T_NONE;
  endfunction
endpackage

// File: rtl/zorro_timeout_cnt.sv
// zorro_timeout_cnt: clearable up-counter with a terminal-count flag
module zorro_timeout_cnt #(
  parameter int W = 7,
  parameter int TC = 63
) (
  input  logic clk,
  input  logic IORST_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge IORST_n)
    if (!IORST_n) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 1'b1;
  assign tc = count == W'(TC);
endmodule

// File: rtl/zorro_cycle_ctrl.sv
// zorro_cycle_ctrl: Zorro III slave-cycle sequencer selecting ROM, SCSI chip or SCSI-ID register
module zorro_cycle_ctrl import zorro_pkg::*; #(
  parameter logic [3:0] ROM_SEL = ROM_SEL_DEF,
  parameter logic [3:0] SCSI_SEL = SCSI_SEL_DEF,
  parameter logic [3:0] SID_SEL = SID_SEL_DEF,
  parameter int TIMEOUT = 64,
  parameter int TO_W = 7
) (
  input  logic       clk,
  input  logic       IORST_n,
  input  logic       FCS_n,
  input  logic       match,
  input  logic [3:0] ADDR,
  input  logic       READ,
  input  logic       DOE,
  input  logic [3:0] DS_n,
  input  logic       rom_ack,
  input  logic       scsi_ack,
  input  logic       sid_ack,
  output logic       rom_cycle,
  output logic       scsi_cycle,
  output logic       sid_cycle,
  output logic       dtack,
  output logic       data_oe,
  output logic       timeout
);
  state_t state;
  target_t target, hit;
  logic tc, ack_hit;
  assign hit = decode_target(ADDR, ROM_SEL, SCSI_SEL, SID_SEL);
  assign ack_hit = (target == T_ROM && rom_ack) || (target == T_SCSI && scsi_ack) ||
                   (target == T_SID && sid_ack);
  zorro_timeout_cnt #(.W(TO_W), .TC(TIMEOUT - 1)) u_cnt (
    .clk(clk),
    .IORST_n(IORST_n),
    .clr(state == RECOVER),
    .en(state == ACTIVE),
    .tc(tc)
  );
  always_ff @(posedge clk or negedge IORST_n)
    if (!IORST_n) begin
      state <= IDLE;
      target <= T_NONE;
      {rom_cycle, scsi_cycle, sid_cycle, dtack, data_oe, timeout} <= '0;
    end else begin
      case (state)
        IDLE: state <= !FCS_n && match ? DECODE : IDLE;
        DECODE:
          if (FCS_n) state <= RECOVER;
          else begin
            target <= hit;
            state <= hit == T_NONE ? ACK : WAIT_DS;
            dtack <= hit == T_NONE;
          end
        WAIT_DS:
          if (FCS_n) state <= RECOVER;
          else if (DOE && DS_n != 4'hF) begin
            state <= ACTIVE;
            rom_cycle <= target == T_ROM;
            scsi_cycle <= target == T_SCSI;
            sid_cycle <= target == T_SID;
            data_oe <= READ;
          end
        ACTIVE:
          // ack wins over a timeout landing on the same clock
          if (FCS_n || ack_hit || tc) begin
            {rom_cycle, scsi_cycle, sid_cycle} <= '0;
            state <= FCS_n ? RECOVER : ACK;
            dtack <= !FCS_n;
            data_oe <= data_oe && !FCS_n;
            if (!FCS_n && !ack_hit) timeout <= 1'b1;
          end
        ACK:
          if (FCS_n) begin
            state <= RECOVER;
            dtack <= 1'b0;
            data_oe <= 1'b0;
          end
        RECOVER: begin
          state <= IDLE;
          target <= T_NONE;
          dtack <= 1'b0;
          data_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_zorro_cycle_ctrl.sv
// tb_zorro_cycle_ctrl: vector table through a scoreboard plus abort and reset sequences
module tb_zorro_cycle_ctrl;
  logic clk = 1'b0, IORST_n = 1'b0, FCS_n = 1'b1, match = 1'b0, READ = 1'b0, DOE = 1'b0;
  logic [3:0] ADDR = 4'h0, DS_n = 4'hF;
  logic rom_ack = 1'b0, scsi_ack = 1'b0, sid_ack = 1'b0;
  logic rom_cycle, scsi_cycle, sid_cycle, dtack, data_oe, timeout;
  int n_cmp = 0, n_fail = 0;
  typedef struct {
    logic [3:0] addr;
    logic read;
    logic [1:0] who;
    int dly;
    logic noise;
    logic [2:0] esel;
    int ecnt;
    logic eoe;
    logic eto;
  } vec_t;
  typedef struct {
    logic [2:0] sel;
    int cnt;
    logic oe;
    logic to;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[10];

  zorro_cycle_ctrl dut (
    .clk(clk), .IORST_n(IORST_n), .FCS_n(FCS_n), .match(match), .ADDR(ADDR),
    .READ(READ), .DOE(DOE), .DS_n(DS_n), .rom_ack(rom_ack), .scsi_ack(scsi_ack),
    .sid_ack(sid_ack), .rom_cycle(rom_cycle), .scsi_cycle(scsi_cycle),
    .sid_cycle(sid_cycle), .dtack(dtack), .data_oe(data_oe), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] sel3();
    return {rom_cycle, scsi_cycle, sid_cycle};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic end_bus();
    FCS_n = 1'b1; match = 1'b0; DOE = 1'b0; DS_n = 4'hF;
  endtask

  task automatic run_cycle(input vec_t v, input int extra);
    exp_t e;
    logic [2:0] seen = '0;
    int cnt = 0, lat = 0;
    bit done = 0;
    sb.push_back('{v.esel, v.ecnt, v.eoe, v.eto});
    FCS_n = 1'b0; match = 1'b1; ADDR = v.addr; READ = v.read; DOE = 1'b1; DS_n = 4'hE;
    for (int t = 1; t <= 200 && !done; t++) begin
      @(negedge clk);
      {rom_ack, scsi_ack, sid_ack} = '0;
      if ((sel3() != 0 || dtack) && lat == 0) lat = t;
      if (sel3() != 0) begin
        seen |= sel3();
        cnt++;
        if (cnt == v.dly) {rom_ack, scsi_ack, sid_ack} = {v.who == 2'd1, v.who == 2'd2, v.who == 2'd3};
        if (v.noise && cnt == 1) rom_ack = 1'b1;
      end
      if (dtack) begin
        done = 1;
        if (sb.size() == 0) chk("sb_empty", dtack, 0);
        else begin
          e = sb.pop_front();
          chk("sel_seen", seen, e.sel);
          chk("sel_clocks", cnt, e.cnt);
          chk("data_oe", data_oe, e.oe);
          chk("timeout", timeout, e.to);
          chk("sel_off_at_dtack", sel3(), 0);
          chk("latency", lat, (e.sel != 0 ? 3 : 2) + extra);
        end
      end
    end
    if (!done) chk("dtack_wait", dtack, 1);
    repeat (2) begin
      @(negedge clk);
      chk("dtack_hold", dtack, 1);
      chk("oe_hold", data_oe, v.eoe);
    end
    end_bus();
    @(negedge clk);
    chk("recover", {sel3(), dtack, data_oe}, 0);
    @(negedge clk);
  endtask

  initial begin
    int w;
    //            addr  rd  who  dly nz  esel    cnt oe  to
    tbl[0] = '{4'hC, 1'b0, 2'd3, 1, 1'b0, 3'b001, 1, 1'b0, 1'b0};
    tbl[1] = '{4'hC, 1'b1, 2'd3, 2, 1'b0, 3'b001, 2, 1'b1, 1'b0};
    tbl[2] = '{4'h0, 1'b1, 2'd1, 1, 1'b0, 3'b100, 1, 1'b1, 1'b0};
    tbl[3] = '{4'h8, 1'b0, 2'd2, 3, 1'b0, 3'b010, 3, 1'b0, 1'b0};
    tbl[4] = '{4'h4, 1'b1, 2'd0, 0, 1'b0, 3'b000, 0, 1'b0, 1'b0};
    tbl[5] = '{4'hC, 1'b0, 2'd3, 2, 1'b1, 3'b001, 2, 1'b0, 1'b0};
    tbl[6] = '{4'h8, 1'b0, 2'd2, 64, 1'b0, 3'b010, 64, 1'b0, 1'b0};
    tbl[7] = '{4'h8, 1'b1, 2'd0, 0, 1'b0, 3'b010, 64, 1'b1, 1'b1};
    tbl[8] = '{4'hC, 1'b0, 2'd3, 1, 1'b0, 3'b001, 1, 1'b0, 1'b1};
    tbl[9] = '{4'hF, 1'b0, 2'd0, 0, 1'b0, 3'b000, 0, 1'b0, 1'b1};
    @(negedge clk);
    chk("reset_outputs", {sel3(), dtack, data_oe, timeout}, 0);
    IORST_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) run_cycle(tbl[i], 0);
    // abort in ACTIVE, then a cycle started during the dead clock
    FCS_n = 1'b0; match = 1'b1; ADDR = 4'h8; READ = 1'b1; DOE = 1'b1; DS_n = 4'h0;
    w = 0;
    while (!scsi_cycle && w < 20) begin @(negedge clk); w++; end
    chk("abort_sel", scsi_cycle, 1);
    end_bus();
    @(negedge clk);
    chk("abort_drop", {sel3(), dtack, data_oe}, 0);
    run_cycle('{4'hC, 1'b0, 2'd3, 1, 1'b0, 3'b001, 1, 1'b0, 1'b1}, 1);
    // reset while in ACK
    FCS_n = 1'b0; match = 1'b1; ADDR = 4'h0; READ = 1'b1; DOE = 1'b1; DS_n = 4'h7;
    w = 0;
    while (!rom_cycle && w < 20) begin @(negedge clk); w++; end
    rom_ack = 1'b1;
    @(negedge clk);
    rom_ack = 1'b0;
    chk("rst_pre_ack", {dtack, data_oe, timeout}, 3'b111);
    #2 IORST_n = 1'b0;
    #1 chk("rst_async", {sel3(), dtack, data_oe, timeout}, 0);
    @(negedge clk);
    end_bus();
    IORST_n = 1'b1;
    @(negedge clk);
    run_cycle('{4'hC, 1'b1, 2'd3, 2, 1'b0, 3'b001, 2, 1'b1, 1'b0}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
